// File: rtl/lut_neuron_arbiter.sv
`default_nettype none
// ============================================================================
// lut_neuron_arbiter: serially loaded 2^IN_BITS x 1 neuron truth table shared
// by NUM_REQ requesters under round-robin arbitration. Rev 1.0
// ============================================================================
module lut_neuron_arbiter #(
  parameter int IN_BITS = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start_i,
  input  logic                       cfg_we_i,
  input  logic                       cfg_bit_i,
  output logic                       cfg_loaded_o,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*IN_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       rsp_valid_o,
  output logic                       rsp_bit_o,
  output logic [ID_W-1:0]            rsp_id_o,
  input  logic                       rsp_ready_i
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [IN_BITS:0] LAST_IDX = (IN_BITS+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IN_BITS:0]   idx_q, idx_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_bit_q, rsp_bit_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  // Table contents are deliberately not reset; they are valid only after a full load.
  logic               table_q [DEPTH];

  logic               tbl_we;
  logic [IN_BITS-1:0] tbl_waddr;
  logic               grant_en;
  logic               grant_found;
  logic               grant;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IN_BITS-1:0] sel_data;
  logic               lookup_bit;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tbl_we    = 1'b0;
    tbl_waddr = idx_q[IN_BITS-1:0];
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        // A restart that carries a write stores it at entry 0.
        if (cfg_start_i) begin
          tbl_waddr = '0;
          tbl_we    = cfg_we_i;
          idx_d     = cfg_we_i ? (IN_BITS+1)'(1) : '0;
        end else if (cfg_we_i) begin
          tbl_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + (IN_BITS+1)'(1);
          end
        end
      end
      ST_RUN: begin
        if (cfg_start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    grant_en     = (state_q == ST_RUN) && !cfg_start_i && (!rsp_valid_q || rsp_ready_i);
    grant_found  = 1'b0;
    grant_id     = last_grant_q;
    cand         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    grant        = grant_en && grant_found;
    grant_onehot = '0;
    if (grant) begin
      grant_onehot[grant_id] = 1'b1;
    end
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_data = req_data_i[k*IN_BITS +: IN_BITS];
      end
    end
    lookup_bit = table_q[sel_data];
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_bit_d    = rsp_bit_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      rsp_valid_d  = 1'b1;
      rsp_bit_d    = lookup_bit;
      rsp_id_d     = grant_id;
      last_grant_d = grant_id;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_bit_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_bit_q    <= rsp_bit_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[tbl_waddr] <= cfg_bit_i;
    end
  end

  assign cfg_loaded_o = (state_q == ST_RUN);
  assign req_ready_o  = grant_onehot;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_bit_o    = rsp_bit_q;
  assign rsp_id_o     = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lut_neuron_arbiter: directed self-checking bench for lut_neuron_arbiter.
// Rev 1.0
// ============================================================================
module tb_lut_neuron_arbiter;

  localparam int IN_BITS = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DEPTH   = 256;

  logic                       clk;
  logic                       rst;
  logic                       cfg_start;
  logic                       cfg_we;
  logic                       cfg_bit;
  logic                       cfg_loaded;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*IN_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       rsp_valid;
  logic                       rsp_bit;
  logic [ID_W-1:0]            rsp_id;
  logic                       rsp_ready;

  int n_chk;
  int n_fail;

  lut_neuron_arbiter #(
    .IN_BITS (IN_BITS),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start_i  (cfg_start),
    .cfg_we_i     (cfg_we),
    .cfg_bit_i    (cfg_bit),
    .cfg_loaded_o (cfg_loaded),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_bit_o    (rsp_bit),
    .rsp_id_o     (rsp_id),
    .rsp_ready_i  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // sel 0: table[i]=i[7]; sel 1: table[i]=i[0]
  task automatic load_table(input bit do_start, input int sel, input int n_writes);
    logic rr_seen;
    if (do_start) begin
      cfg_start = 1'b1;
      cfg_we    = 1'b0;
      cycle();
      cfg_start = 1'b0;
    end
    rr_seen = 1'b0;
    for (int i = 0; i < n_writes; i++) begin
      cfg_we  = 1'b1;
      cfg_bit = (sel == 1) ? i[0] : i[7];
      #1;
      rr_seen = rr_seen | (|req_ready);
      if (i == DEPTH - 1) check("loaded_before_last", cfg_loaded, 0);
      cycle();
    end
    cfg_we = 1'b0;
    check("ready_during_load", rr_seen, 0);
    if (n_writes == DEPTH) check("loaded_after_last", cfg_loaded, 1);
  endtask

  logic [NUM_REQ-1:0] exp_bits;
  int                 seq [3];
  logic               seen;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_we    = 1'b0;
    cfg_bit   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_loaded", cfg_loaded, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bit", rsp_bit, 0);
    check("rst_rsp_id", rsp_id, 0);
    rst = 1'b0;

    // IDLE ignores writes and never grants
    req_valid = 4'hF;
    cfg_we    = 1'b1;
    cfg_bit   = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 seen = seen | (|req_ready);
      cycle();
    end
    cfg_we = 1'b0;
    check("idle_ready", seen, 0);
    check("idle_loaded", cfg_loaded, 0);

    load_table(1'b1, 0, DEPTH);

    // Round robin, all valid, full throughput
    req_data  = {8'h7F, 8'hFF, 8'h00, 8'h80};
    exp_bits  = 4'b0101;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1 check("rr_ready", req_ready, 4'b0001 << (j % 4));
      cycle();
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, j % 4);
      check("rr_rsp_bit", rsp_bit, exp_bits[j%4]);
    end

    // Sparse requesters 1 and 3 after a grant to 3
    req_valid = 4'b1010;
    seq = '{1, 3, 1};
    for (int j = 0; j < 3; j++) begin
      #1 check("sparse_ready", req_ready, 4'b0001 << seq[j]);
      cycle();
      check("sparse_rsp_id", rsp_id, seq[j]);
      check("sparse_rsp_bit", rsp_bit, exp_bits[seq[j]]);
    end

    // Backpressure holds the response and blocks grants
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1 check("bp_ready", req_ready, 0);
      cycle();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_rsp_bit", rsp_bit, 0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_resume_ready", req_ready, 4'b0100);
    cycle();
    check("bp_resume_id", rsp_id, 2);
    check("bp_resume_bit", rsp_bit, 1);
    #1 check("bp_next_ready", req_ready, 4'b1000);
    cycle();
    check("bp_next_id", rsp_id, 3);
    check("bp_next_bit", rsp_bit, 0);

    // Reload from RUN while a response is pending
    rsp_ready = 1'b0;
    cfg_start = 1'b1;
    #1 check("reload_start_ready", req_ready, 0);
    cycle();
    cfg_start = 1'b0;
    check("reload_loaded", cfg_loaded, 0);
    check("reload_hold_valid", rsp_valid, 1);
    check("reload_hold_id", rsp_id, 3);
    check("reload_hold_bit", rsp_bit, 0);
    cycle();
    check("reload_hold2_id", rsp_id, 3);
    rsp_ready = 1'b1;
    #1 check("reload_consume_ready", req_ready, 0);
    cycle();
    check("reload_consumed", rsp_valid, 0);
    load_table(1'b0, 1, DEPTH);

    req_data = {8'h03, 8'hFE, 8'h80, 8'h01};
    exp_bits = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      #1 check("new_tbl_ready", req_ready, 4'b0001 << j);
      cycle();
      check("new_tbl_id", rsp_id, j);
      check("new_tbl_bit", rsp_bit, exp_bits[j]);
    end

    // Asynchronous reset in the middle of a load discards the pending response
    rsp_ready = 1'b0;
    load_table(1'b1, 0, 100);
    check("pre_rst_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_loaded", cfg_loaded, 0);
    check("arst_ready", req_ready, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_bit", rsp_bit, 0);
    check("arst_rsp_id", rsp_id, 0);
    cycle();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    cfg_we    = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 seen = seen | cfg_loaded | (|req_ready);
      cycle();
    end
    cfg_we = 1'b0;
    check("post_rst_idle", seen, 0);
    load_table(1'b1, 0, DEPTH);
    req_data = {8'h00, 8'h00, 8'h00, 8'h80};
    #1 check("post_rst_ready", req_ready, 4'b0001);
    cycle();
    check("post_rst_rsp_id", rsp_id, 0);
    check("post_rst_rsp_bit", rsp_bit, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
